// File: rtl/mem_arbiter.sv
// Single-port memory arbiter that shares one memory port between the CPU core and the VGA fetch.
// VGA has fixed priority. A starvation counter forces a CPU grant after a bounded run of VGA grants.
module mem_arbiter #(
  parameter int unsigned       ADDR_W       = 24,
  parameter int unsigned       DATA_W       = 16,
  parameter int unsigned       VGA_ADDR_W   = 15,
  parameter logic [ADDR_W-1:0] VGA_BASE     = '0,
  parameter int unsigned       MEM_LATENCY  = 2,
  parameter int unsigned       STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  vga_req,
  input  logic [VGA_ADDR_W-1:0] vga_addr,
  output logic                  vga_valid,
  output logic [DATA_W-1:0]     vga_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int unsigned LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic               owner_vga_q, owner_vga_d;

  logic               mem_en_d, mem_we_d, cpu_ack_d, vga_valid_d, busy_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_d, cpu_rdata_d, vga_rdata_d;

  // The mem_* registers double as the latched request; they load on the grant edge.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    owner_vga_d = owner_vga_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_ack_d   = 1'b0;
    vga_valid_d = 1'b0;
    cpu_rdata_d = cpu_rdata;
    vga_rdata_d = vga_rdata;

    unique case (state_q)
      ST_IDLE: begin
        if (!cpu_req) begin
          starve_d = '0;
        end
        if (vga_req && (!cpu_req || (starve_q < STV_MAX))) begin
          owner_vga_d = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = VGA_BASE + ADDR_W'(vga_addr);
          mem_wdata_d = '0;
          state_d     = ST_ISSUE;
          // Winning here with cpu_req high implies starve_q < STV_MAX, so no overflow.
          if (cpu_req) begin
            starve_d = starve_q + STV_W'(1);
          end
        end else if (cpu_req) begin
          owner_vga_d = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          starve_d    = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_cnt_d = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = ST_DONE;
          if (owner_vga_q) begin
            vga_valid_d = 1'b1;
            vga_rdata_d = mem_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (!mem_we) begin
              cpu_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      owner_vga_q <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
      vga_valid   <= 1'b0;
      vga_rdata   <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      owner_vga_q <= owner_vga_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_ack     <= cpu_ack_d;
      cpu_rdata   <= cpu_rdata_d;
      vga_valid   <= vga_valid_d;
      vga_rdata   <= vga_rdata_d;
      busy        <= busy_d;
    end
  end

endmodule
